// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: keymap, frame-result
// encoding, scan FSM states and the frame decode helper.
package keypad_pkg;

    // Scan FSM: drive columns one at a time, then one evaluation cycle.
    typedef enum logic [0:0] {
        ST_SCAN = 1'b0,
        ST_EVAL = 1'b1
    } scan_state_e;

    // Result of one complete scan frame.
    typedef struct packed {
        logic       present;
        logic [3:0] code;
    } frame_result_t;

    localparam frame_result_t NO_KEY = '{present: 1'b0, code: 4'h0};

    // Keymap indexed by row*4 + col; rows r0..r3 run top to bottom.
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // hits is laid out column-major: bit (col*4 + row) set means that
    // row read low while that column was driven. Exactly one hit yields a
    // key; zero or several hits (multi-press / ghosting) yield NO_KEY.
    function automatic frame_result_t decode_frame(input logic [15:0] hits);
        frame_result_t res;
        logic [4:0]    n;
        res = NO_KEY;
        n   = 5'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (hits[4'(c * 4 + r)]) begin
                    n        = n + 5'd1;
                    res.code = KEYMAP[4'(r * 4 + c)];
                end
            end
        end
        if (n == 5'd1) begin
            res.present = 1'b1;
        end else begin
            res = NO_KEY;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Frame-level debouncer: a frame result must repeat DEBOUNCE_CNT times in a
// row before it is accepted. Acceptance strobes once, on the evaluation where
// the run length first reaches DEBOUNCE_CNT.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          eval_i,
    input  frame_result_t result_i,
    output logic          accept_o,
    output frame_result_t result_o
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

    frame_result_t cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // Track the current candidate and how many consecutive frames matched it.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (eval_i) begin
            if (result_i == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_q == CNT_MAX - 1'b1) begin
                    accept = 1'b1;
                end
            end else begin
                cand_d = result_i;
                cnt_d  = CW'(1);
                accept = (DEBOUNCE_CNT == 1);
            end
        end
    end

    // Candidate and run-length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= NO_KEY;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    assign accept_o = accept;
    assign result_o = cand_d;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, collects the
// synchronized rows into a frame, decodes and debounces each frame, and
// reports accepted keys plus the last two digits for the display driver.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [7:0] digits
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    scan_state_e   state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    col_out_q, col_out_d;
    logic [3:0]    row_meta_q, row_sync_q;
    logic [15:0]   frame_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_held_q;
    logic [7:0]    digits_q;

    logic          sample;
    logic          eval;
    frame_result_t frame_result;
    logic          accept;
    frame_result_t accepted;

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
        end
    end

    // Scan sequencing: dwell on each column, then one evaluation cycle.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (col_q == 2'd3) begin
                        state_d = ST_EVAL;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_EVAL: begin
                state_d = ST_SCAN;
                col_d   = 2'd0;
                dwell_d = '0;
            end
            default: begin
                state_d = ST_SCAN;
                col_d   = 2'd0;
                dwell_d = '0;
            end
        endcase
        col_out_d = (state_d == ST_EVAL) ? 4'b1111 : ~(4'b0001 << col_d);
    end

    // Scan state and registered column drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SCAN;
            col_q     <= 2'd0;
            dwell_q   <= '0;
            col_out_q <= 4'b1110;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            dwell_q   <= dwell_d;
            col_out_q <= col_out_d;
        end
    end

    // Rows are read on the last dwell cycle so the synchronizer has settled
    // on the current column. Each frame overwrites every column slice.
    assign sample = (state_q == ST_SCAN) && (dwell_q == DWELL_LAST);

    // Frame accumulator, stored active-high (1 = row pulled low).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (sample) begin
            frame_q[{col_q, 2'b00} +: 4] <= ~row_sync_q;
        end
    end

    assign eval         = (state_q == ST_EVAL);
    assign frame_result = decode_frame(frame_q);

    key_debouncer #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debouncer (
        .clk     (clk),
        .rst_n   (rst_n),
        .eval_i  (eval),
        .result_i(frame_result),
        .accept_o(accept),
        .result_o(accepted)
    );

    // Key reporting: a press pulses and shifts digits, a release clears held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            digits_q    <= 8'h00;
        end else begin
            key_valid_q <= 1'b0;
            if (accept) begin
                if (accepted.present) begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= accepted.code;
                    key_held_q  <= 1'b1;
                    digits_q    <= {digits_q[3:0], accepted.code};
                end else begin
                    key_held_q <= 1'b0;
                end
            end
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3
// (17-cycle frames). A keypad model pulls rows low for pressed keys.
module tb_keypad_scanner;

    localparam int FRAME = 17;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [7:0] digits;

    logic [15:0] pressed;   // bit r*4+c = key at row r, column c held down
    int          checks;
    int          failures;
    int          pulse_cnt;

    keypad_scanner #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .digits   (digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model: a pressed key shorts its row to its driven column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r * 4 + c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    // Count key_valid pulses, sampled just before each rising edge updates it.
    always @(posedge clk) begin
        if (key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Align to the evaluation cycle (col_out all high), bounded.
    task automatic wait_eval();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (col_out === 4'b1111) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wait_eval: col_out never reached 1111 (last %b)", col_out);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        int         ph;
        rst_n   = 1'b0;
        pressed = '0;
        wait_cycles(3);
        checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL rst_col_out got=%b exp=1110", col_out); end
        checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL rst_key_code got=%h exp=0", key_code); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_key_valid got=%b exp=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rst_key_held got=%b exp=0", key_held); end
        checks++; if (digits !== 8'h00) begin failures++; $display("FAIL rst_digits got=%h exp=00", digits); end
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            ph = i % FRAME;
            if (ph < 4)       exp_col = 4'b1110;
            else if (ph < 8)  exp_col = 4'b1101;
            else if (ph < 12) exp_col = 4'b1011;
            else if (ph < 16) exp_col = 4'b0111;
            else              exp_col = 4'b1111;
            checks++;
            if (col_out !== exp_col) begin
                failures++;
                $display("FAIL scan_seq[%0d] got=%b exp=%b", i, col_out, exp_col);
            end
            @(negedge clk);
        end
        $display("test_reset done: col_out scan sequence checked over 2 frames");
    endtask

    task automatic test_single_press();
        int base;
        wait_eval();
        base = pulse_cnt;
        pressed[1 * 4 + 1] = 1'b1;            // '5'
        wait_cycles(3 * FRAME);               // third frame's evaluation cycle
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL press5_early_valid got=%b exp=0", key_valid); end
        checks++; if (pulse_cnt !== base) begin failures++; $display("FAIL press5_early_pulses got=%0d exp=%0d", pulse_cnt - base, 0); end
        wait_cycles(1);
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL press5_valid got=%b exp=1", key_valid); end
        checks++; if (key_code !== 4'h5) begin failures++; $display("FAIL press5_code got=%h exp=5", key_code); end
        wait_cycles(10 * FRAME - 3 * FRAME - 1);
        checks++; if (pulse_cnt !== base + 1) begin failures++; $display("FAIL press5_pulses got=%0d exp=1", pulse_cnt - base); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press5_held got=%b exp=1", key_held); end
        checks++; if (digits !== 8'h05) begin failures++; $display("FAIL press5_digits got=%h exp=05", digits); end
        $display("test_single_press: code=%h digits=%h pulses=%0d", key_code, digits, pulse_cnt - base);
    endtask

    task automatic test_release();
        int base;
        wait_eval();
        base = pulse_cnt;
        pressed = '0;
        wait_cycles(3 * FRAME);
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL rel5_held_early got=%b exp=1", key_held); end
        wait_cycles(1);
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rel5_held got=%b exp=0", key_held); end
        checks++; if (digits !== 8'h05) begin failures++; $display("FAIL rel5_digits got=%h exp=05", digits); end
        checks++; if (key_code !== 4'h5) begin failures++; $display("FAIL rel5_code got=%h exp=5", key_code); end
        checks++; if (pulse_cnt !== base) begin failures++; $display("FAIL rel5_pulses got=%0d exp=0", pulse_cnt - base); end
        $display("test_release: held=%b digits=%h", key_held, digits);
    endtask

    task automatic test_bounce();
        int base;
        wait_eval();
        base = pulse_cnt;
        for (int f = 0; f < 4; f++) begin
            pressed[2 * 4 + 2] = (f % 2 == 0);  // '9' on, off, on, off
            wait_cycles(FRAME);
        end
        pressed[2 * 4 + 2] = 1'b1;
        wait_cycles(3 * FRAME);
        checks++; if (pulse_cnt !== base) begin failures++; $display("FAIL bounce_early_pulses got=%0d exp=0", pulse_cnt - base); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bounce_early_valid got=%b exp=0", key_valid); end
        wait_cycles(1);
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL bounce_valid got=%b exp=1", key_valid); end
        wait_cycles(FRAME);
        checks++; if (pulse_cnt !== base + 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=1", pulse_cnt - base); end
        checks++; if (key_code !== 4'h9) begin failures++; $display("FAIL bounce_code got=%h exp=9", key_code); end
        checks++; if (digits !== 8'h59) begin failures++; $display("FAIL bounce_digits got=%h exp=59", digits); end
        $display("test_bounce: code=%h digits=%h pulses=%0d", key_code, digits, pulse_cnt - base);
    endtask

    task automatic test_ghost();
        int base;
        pressed = '0;
        wait_cycles(5 * FRAME);
        base = pulse_cnt;
        pressed[0] = 1'b1;                    // '1'
        pressed[1] = 1'b1;                    // '2'
        wait_cycles(5 * FRAME);
        checks++; if (pulse_cnt !== base) begin failures++; $display("FAIL ghost_pulses got=%0d exp=0", pulse_cnt - base); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL ghost_held got=%b exp=0", key_held); end
        checks++; if (key_code !== 4'h9) begin failures++; $display("FAIL ghost_code got=%h exp=9", key_code); end
        pressed[0] = 1'b0;
        wait_cycles(5 * FRAME);
        checks++; if (pulse_cnt !== base + 1) begin failures++; $display("FAIL ghost_rel_pulses got=%0d exp=1", pulse_cnt - base); end
        checks++; if (key_code !== 4'h2) begin failures++; $display("FAIL ghost_rel_code got=%h exp=2", key_code); end
        checks++; if (digits !== 8'h92) begin failures++; $display("FAIL ghost_rel_digits got=%h exp=92", digits); end
        $display("test_ghost: code=%h digits=%h pulses=%0d", key_code, digits, pulse_cnt - base);
    endtask

    task automatic test_sequence();
        int base;
        pressed = '0;
        wait_cycles(5 * FRAME);
        base = pulse_cnt;
        pressed[0] = 1'b1;                    // '1'
        wait_cycles(5 * FRAME);
        pressed = '0;
        wait_cycles(5 * FRAME);
        pressed[3] = 1'b1;                    // 'A'
        wait_cycles(5 * FRAME);
        pressed = '0;
        wait_cycles(5 * FRAME);
        checks++; if (pulse_cnt !== base + 2) begin failures++; $display("FAIL seq1A_pulses got=%0d exp=2", pulse_cnt - base); end
        checks++; if (digits !== 8'h1A) begin failures++; $display("FAIL seq1A_digits got=%h exp=1a", digits); end
        pressed[2] = 1'b1;                    // '3'
        wait_cycles(5 * FRAME);
        pressed = '0;
        pressed[3 * 4 + 2] = 1'b1;            // slide directly to 'E'
        wait_cycles(5 * FRAME);
        checks++; if (pulse_cnt !== base + 4) begin failures++; $display("FAIL seq3E_pulses got=%0d exp=4", pulse_cnt - base); end
        checks++; if (digits !== 8'h3E) begin failures++; $display("FAIL seq3E_digits got=%h exp=3e", digits); end
        checks++; if (key_code !== 4'hE) begin failures++; $display("FAIL seq3E_code got=%h exp=e", key_code); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL seq3E_held got=%b exp=1", key_held); end
        $display("test_sequence: code=%h digits=%h pulses=%0d", key_code, digits, pulse_cnt - base);
    endtask

    task automatic test_reset_mid_debounce();
        int base;
        pressed = '0;
        wait_cycles(5 * FRAME);
        wait_eval();
        base = pulse_cnt;
        pressed[2 * 4 + 0] = 1'b1;            // '7'
        wait_cycles(2 * FRAME);
        rst_n = 1'b0;
        wait_cycles(2);
        checks++; if (col_out !== 4'b1110) begin failures++; $display("FAIL midrst_col_out got=%b exp=1110", col_out); end
        checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL midrst_code got=%h exp=0", key_code); end
        checks++; if (digits !== 8'h00) begin failures++; $display("FAIL midrst_digits got=%h exp=00", digits); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL midrst_held got=%b exp=0", key_held); end
        rst_n = 1'b1;
        wait_cycles(3 * FRAME - 1);
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL midrst_early_valid got=%b exp=0", key_valid); end
        checks++; if (pulse_cnt !== base) begin failures++; $display("FAIL midrst_early_pulses got=%0d exp=0", pulse_cnt - base); end
        wait_cycles(1);
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL midrst_valid got=%b exp=1", key_valid); end
        checks++; if (key_code !== 4'h7) begin failures++; $display("FAIL midrst_code7 got=%h exp=7", key_code); end
        checks++; if (digits !== 8'h07) begin failures++; $display("FAIL midrst_digits07 got=%h exp=07", digits); end
        wait_cycles(1);
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL midrst_pulse_width got=%b exp=0", key_valid); end
        $display("test_reset_mid_debounce: code=%h digits=%h", key_code, digits);
    endtask

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        pulse_cnt = 0;
        pressed   = '0;
        rst_n     = 1'b0;
        test_reset();
        test_single_press();
        test_release();
        test_bounce();
        test_ghost();
        test_sequence();
        test_reset_mid_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
